// File: rtl/watch_key_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | watch_key_sequencer                                                        |
// | Push-button front end: synchronise, debounce, press pulses, mode register, |
// | per-mode routing and optional auto-repeat (macro WATCH_AUTO_REPEAT_EN).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module watch_key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [1:0] mode,
  output logic [3:0] key0_out,
  output logic [3:0] key1_out,
  output logic [3:0] key2_out,
  output logic [3:0] key_held
);

  typedef enum logic [1:0] {
    CLOCK     = 2'd1,
    STOPWATCH = 2'd2,
    TIMER     = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time guard: every terminal count must fit the counters.
  generate
    if ((DEBOUNCE_CYCLES < 1) || (HOLD_CYCLES < 1) || (REPEAT_CYCLES < 1) ||
        (DEBOUNCE_CYCLES > (1 << CNT_W)) || (HOLD_CYCLES > (1 << CNT_W)) ||
        (REPEAT_CYCLES > (1 << CNT_W))) begin : g_bad_cfg
      $error("watch_key_sequencer: counts must be >= 1 and fit in CNT_W bits");
    end
  endgenerate

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       deb;
  logic [3:0]       deb_prev;
  logic [3:0]       press_evt;
  logic [CNT_W-1:0] db_cnt [4];
  logic [2:0]       route_evt;
  logic             mode_chg;
  mode_t            state;

  assign mode_chg = press_evt[3];
  assign mode     = state;
  assign key_held = deb;

  // Synchroniser, debounce and press-edge detection for all four keys.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 4'hF;
      sync2     <= 4'hF;
      deb       <= 4'h0;
      deb_prev  <= 4'h0;
      press_evt <= 4'h0;
      for (int k = 0; k < 4; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      deb_prev  <= deb;
      press_evt <= deb & ~deb_prev;
      for (int k = 0; k < 4; k++) begin
        if (~sync2[k] != deb[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            deb[k]    <= ~sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + CNT_W'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

`ifdef WATCH_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       rpt_active;
  logic [1:0]       rpt_first;
  logic [1:0]       rpt_evt;
  logic [CNT_W-1:0] rpt_cnt [2];

  // Counters start on the same edge the press pulse is raised, so after
  // edge e0+k the count equals k and the first repeat lands at e0+HOLD.
  // A mode change kills running repeats; only a fresh press restarts them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rpt_active <= 2'b00;
      rpt_first  <= 2'b00;
      rpt_evt    <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        rpt_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rpt_evt[k] <= 1'b0;
        if (deb[k] && !deb_prev[k]) begin
          rpt_active[k] <= 1'b1;
          rpt_first[k]  <= 1'b1;
          rpt_cnt[k]    <= '0;
        end else if (!deb[k] || mode_chg) begin
          rpt_active[k] <= 1'b0;
          rpt_cnt[k]    <= '0;
        end else if (rpt_active[k]) begin
          if ((rpt_first[k] && (rpt_cnt[k] == HOLD_LAST)) ||
              (!rpt_first[k] && (rpt_cnt[k] == RPT_LAST))) begin
            rpt_evt[k]   <= 1'b1;
            rpt_first[k] <= 1'b0;
            rpt_cnt[k]   <= '0;
          end else begin
            rpt_cnt[k] <= rpt_cnt[k] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign route_evt = press_evt[2:0] | {1'b0, rpt_evt};
`else
  assign route_evt = press_evt[2:0];
`endif

  // Mode FSM with registered routing; events in the key3 cycle use the old mode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= CLOCK;
      key0_out <= 4'h0;
      key1_out <= 4'h0;
      key2_out <= 4'h0;
    end else begin
      key0_out <= route_evt[0] ? (4'b0001 << state) : 4'h0;
      key1_out <= route_evt[1] ? (4'b0001 << state) : 4'h0;
      key2_out <= route_evt[2] ? (4'b0001 << state) : 4'h0;
      if (mode_chg) begin
        case (state)
          CLOCK:     state <= STOPWATCH;
          STOPWATCH: state <= TIMER;
          default:   state <= CLOCK;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
